// File: rtl/spi_slave_device_if.sv
// SPI pin bundle between a master and the spi_slave_device.
interface spi_slave_device_if;
    logic SCK;
    logic CSbar;
    logic MOSI;
    logic MISO;
    logic MISO_OE;

    modport master (output SCK, output CSbar, output MOSI, input MISO, input MISO_OE);
    modport slave  (input SCK, input CSbar, input MOSI, output MISO, output MISO_OE);
endinterface

// File: rtl/spi_slave_device.sv
// Mode-0, MSB-first SPI slave oversampled in the SYS_CLK domain.
// Deserialises MOSI into DATA_RX and serialises DATA_TX (captured at
// chip-select fall) onto MISO.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for CSbar fall, SCK ignored, MISO tristated
// ST_SHIFT | frame in progress, shifting on synchronised SCK edges
// ST_DONE  | full word received, extra SCK ignored until CSbar rises
module spi_slave_device #(
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic               SYS_CLK,
    input  logic               RSTbar,
    spi_slave_device_if.slave  spi,
    input  logic [WIDTH-1:0]   DATA_TX,
    output logic [WIDTH-1:0]   DATA_RX,
    output logic               RX_VALID,
    output logic               FRAME_ERR,
    output logic               BUSY
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0] sck_sync_q;
    logic [SYNC_STAGES-1:0] cs_sync_q;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic                   sck_hist_q;
    logic                   cs_hist_q;

    state_t           state_q,     state_d;
    logic [CW-1:0]    cnt_q,       cnt_d;
    logic [WIDTH-1:0] rx_shift_q,  rx_shift_d;
    logic [WIDTH-1:0] tx_shift_q,  tx_shift_d;
    logic [WIDTH-1:0] data_rx_q,   data_rx_d;
    logic             rx_valid_q,  rx_valid_d;
    logic             frame_err_q, frame_err_d;

    logic sck_s, cs_s, mosi_s;
    logic sck_rise, sck_fall, cs_fall, cs_rise;

    // Synchronisers and one-cycle edge history; reset to the bus idle levels.
    always_ff @(posedge SYS_CLK or negedge RSTbar) begin
        if (!RSTbar) begin
            sck_sync_q  <= '0;
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            sck_hist_q  <= 1'b0;
            cs_hist_q   <= 1'b1;
        end else begin
            sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0],  spi.SCK};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0],   spi.CSbar};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi.MOSI};
            sck_hist_q  <= sck_sync_q[SYNC_STAGES-1];
            cs_hist_q   <= cs_sync_q[SYNC_STAGES-1];
        end
    end

    assign sck_s    = sck_sync_q[SYNC_STAGES-1];
    assign cs_s     = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
    assign sck_rise =  sck_s & ~sck_hist_q;
    assign sck_fall = ~sck_s &  sck_hist_q;
    assign cs_fall  = ~cs_s  &  cs_hist_q;
    assign cs_rise  =  cs_s  & ~cs_hist_q;

    // Frame state, shift registers and registered output pulses.
    always_ff @(posedge SYS_CLK or negedge RSTbar) begin
        if (!RSTbar) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            rx_shift_q  <= '0;
            tx_shift_q  <= '0;
            data_rx_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rx_shift_q  <= rx_shift_d;
            tx_shift_q  <= tx_shift_d;
            data_rx_q   <= data_rx_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
        end
    end

    // Next-state logic. The word is committed on the cycle after the final
    // detected SCK rise; a CSbar rise in that same cycle is a clean end of
    // frame, so the FSM goes straight to IDLE instead of waiting in DONE.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rx_shift_d  = rx_shift_q;
        tx_shift_d  = tx_shift_q;
        data_rx_d   = data_rx_q;
        rx_valid_d  = 1'b0;
        frame_err_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cs_fall) begin
                    tx_shift_d = DATA_TX;
                    cnt_d      = '0;
                    state_d    = ST_SHIFT;
                end
            end

            ST_SHIFT: begin
                if (sck_rise) begin
                    rx_shift_d = {rx_shift_q[WIDTH-2:0], mosi_s};
                    cnt_d      = cnt_q + CNT_ONE;
                    if (cnt_q == CNT_LAST) begin
                        data_rx_d  = {rx_shift_q[WIDTH-2:0], mosi_s};
                        rx_valid_d = 1'b1;
                        state_d    = cs_s ? ST_IDLE : ST_DONE;
                    end
                end else if (sck_fall && (cnt_q >= CNT_ONE) && (cnt_q <= CNT_LAST)) begin
                    tx_shift_d = {tx_shift_q[WIDTH-2:0], 1'b0};
                end

                if (cs_rise && !(sck_rise && (cnt_q == CNT_LAST))) begin
                    frame_err_d = 1'b1;
                    state_d     = ST_IDLE;
                end
            end

            ST_DONE: begin
                if (cs_rise) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign spi.MISO    = (state_q == ST_SHIFT) ? tx_shift_q[WIDTH-1] : 1'b0;
    assign spi.MISO_OE = (state_q != ST_IDLE);
    assign BUSY        = (state_q != ST_IDLE);
    assign DATA_RX     = data_rx_q;
    assign RX_VALID    = rx_valid_q;
    assign FRAME_ERR   = frame_err_q;

endmodule

// File: tb/tb_spi_slave_device.sv
// Directed bench for spi_slave_device: bit-banged mode-0 master at
// SCK = SYS_CLK/8, with hand-computed expected words.
module tb_spi_slave_device;

    logic        clk_sys;
    logic        rst_b;
    logic [15:0] data_tx;
    logic [15:0] data_rx;
    logic        rx_valid;
    logic        frame_err;
    logic        busy;

    int n_checks = 0;
    int n_pass   = 0;
    int rx_pulses = 0;
    int fe_pulses = 0;
    int oe_seen   = 0;

    spi_slave_device_if spi ();

    spi_slave_device #(.WIDTH(16), .SYNC_STAGES(2)) dut (
        .SYS_CLK   (clk_sys),
        .RSTbar    (rst_b),
        .spi       (spi.slave),
        .DATA_TX   (data_tx),
        .DATA_RX   (data_rx),
        .RX_VALID  (rx_valid),
        .FRAME_ERR (frame_err),
        .BUSY      (busy)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    always @(negedge clk_sys) begin
        if (rx_valid)    rx_pulses++;
        if (frame_err)   fe_pulses++;
        if (spi.MISO_OE) oe_seen++;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    // One CSbar window of nbits SCK pulses; MOSI beyond bit 16 is 0.
    // DATA_TX is switched to tx_after once bit 4 has gone out.
    task automatic frame(input logic [15:0] word, input int nbits, input bit raise_cs,
                         input logic [15:0] tx_after,
                         output logic [15:0] miso_word, output logic rv_lat,
                         output logic miso_extra);
        miso_word  = '0;
        rv_lat     = 1'b0;
        miso_extra = 1'b0;
        spi.CSbar  = 1'b0;
        tick(8);
        for (int i = 0; i < nbits; i++) begin
            spi.MOSI = (i < 16) ? word[15-i] : 1'b0;
            if (i == 4) data_tx = tx_after;
            tick(4);
            if (i < 16) miso_word[15-i] = spi.MISO;
            else        miso_extra = miso_extra | spi.MISO;
            spi.SCK = 1'b1;
            if (i == 15) begin
                tick(3);
                rv_lat = rx_valid;
                tick(1);
            end else begin
                tick(4);
            end
            spi.SCK = 1'b0;
        end
        tick(4);
        if (raise_cs) begin
            spi.CSbar = 1'b1;
            tick(8);
        end
    endtask

    logic [15:0] mw;
    logic        rv, mx;
    int          rx0, fe0, oe0;

    initial begin
        rst_b     = 1'b0;
        spi.SCK   = 1'b0;
        spi.CSbar = 1'b1;
        spi.MOSI  = 1'b0;
        data_tx   = 16'h0000;
        tick(3);
        check_val("rst_miso",    {31'd0, spi.MISO},    32'd0);
        check_val("rst_oe",      {31'd0, spi.MISO_OE}, 32'd0);
        check_val("rst_data_rx", {16'd0, data_rx},     32'd0);
        check_val("rst_busy",    {31'd0, busy},        32'd0);
        rst_b = 1'b1;
        tick(4);

        // Idle noise
        rx0 = rx_pulses; fe0 = fe_pulses; oe0 = oe_seen;
        for (int i = 0; i < 32; i++) begin
            spi.SCK = ~spi.SCK;
            spi.MOSI = ~spi.MOSI;
            tick(4);
        end
        tick(4);
        check_val("idle_rx_valid", rx_pulses - rx0, 32'd0);
        check_val("idle_frame_err", fe_pulses - fe0, 32'd0);
        check_val("idle_oe", oe_seen - oe0, 32'd0);

        // Nominal frame
        data_tx = 16'h3C5A;
        rx0 = rx_pulses; fe0 = fe_pulses;
        frame(16'hA5C3, 16, 1'b1, 16'h3C5A, mw, rv, mx);
        check_val("nom_data_rx", {16'd0, data_rx}, 32'h0000A5C3);
        check_val("nom_miso",    {16'd0, mw},      32'h00003C5A);
        check_val("nom_pulses",  rx_pulses - rx0,  32'd1);
        check_val("nom_latency", {31'd0, rv},      32'd1);
        check_val("nom_no_err",  fe_pulses - fe0,  32'd0);
        check_val("nom_busy",    {31'd0, busy},    32'd0);

        // Short frame after a good 0x1234
        frame(16'h1234, 16, 1'b1, 16'h0000, mw, rv, mx);
        check_val("pre_data_rx", {16'd0, data_rx}, 32'h00001234);
        rx0 = rx_pulses; fe0 = fe_pulses;
        frame(16'hFFFF, 9, 1'b1, 16'h0000, mw, rv, mx);
        check_val("short_err",      fe_pulses - fe0,  32'd1);
        check_val("short_no_valid", rx_pulses - rx0,  32'd0);
        check_val("short_data_rx",  {16'd0, data_rx}, 32'h00001234);
        check_val("short_busy",     {31'd0, busy},    32'd0);

        // Over-clocked frame
        data_tx = 16'hFFFF;
        rx0 = rx_pulses; fe0 = fe_pulses;
        frame(16'hC3A5, 20, 1'b1, 16'hFFFF, mw, rv, mx);
        check_val("over_data_rx", {16'd0, data_rx}, 32'h0000C3A5);
        check_val("over_pulses",  rx_pulses - rx0,  32'd1);
        check_val("over_miso_hi", {31'd0, mx},      32'd0);
        check_val("over_miso",    {16'd0, mw},      32'h0000FFFF);
        check_val("over_no_err",  fe_pulses - fe0,  32'd0);

        // Reset mid-frame
        rx0 = rx_pulses; fe0 = fe_pulses;
        frame(16'hFFFF, 8, 1'b0, 16'hFFFF, mw, rv, mx);
        check_val("mid_busy_pre", {31'd0, busy}, 32'd1);
        rst_b = 1'b0;
        #1;
        check_val("mid_rst_oe",      {31'd0, spi.MISO_OE}, 32'd0);
        check_val("mid_rst_busy",    {31'd0, busy},        32'd0);
        check_val("mid_rst_data_rx", {16'd0, data_rx},     32'd0);
        check_val("mid_rst_miso",    {31'd0, spi.MISO},    32'd0);
        spi.CSbar = 1'b1;
        spi.SCK   = 1'b0;
        tick(3);
        rst_b = 1'b1;
        tick(4);
        check_val("mid_no_pulses", (rx_pulses - rx0) + (fe_pulses - fe0), 32'd0);
        frame(16'h0001, 16, 1'b1, 16'h0000, mw, rv, mx);
        check_val("post_rst_data_rx", {16'd0, data_rx}, 32'h00000001);

        // Back-to-back frames, DATA_TX changed during frame 1
        data_tx = 16'h1111;
        rx0 = rx_pulses;
        frame(16'h8001, 16, 1'b1, 16'hEEEE, mw, rv, mx);
        check_val("b2b1_miso",    {16'd0, mw},      32'h00001111);
        check_val("b2b1_data_rx", {16'd0, data_rx}, 32'h00008001);
        tick(8);
        frame(16'h7FFE, 16, 1'b1, 16'hEEEE, mw, rv, mx);
        check_val("b2b2_miso",    {16'd0, mw},      32'h0000EEEE);
        check_val("b2b2_data_rx", {16'd0, data_rx}, 32'h00007FFE);
        check_val("b2b_pulses",   rx_pulses - rx0,  32'd2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/spi_slave_device.md
Name: spi_slave_device

Overview:
- 16-bit SPI slave (mode 0, MSB first): the far end of the team's SPI master link.
- Oversamples SCK/CSbar/MOSI in the SYS_CLK domain, deserialises MOSI into a parallel word and serialises a parallel reply word onto MISO.
- Used in FPGA-to-FPGA links and as the loopback model for verifying the master on-chip.

Parameters:
- WIDTH, 16, frame length in bits; also the width of DATA_TX and DATA_RX.
- SYNC_STAGES, 2, flip-flop synchroniser depth on SCK, CSbar and MOSI; minimum 2.

Ports:
- SYS_CLK  input  1  system clock; must be at least 4x the SCK frequency.
- RSTbar  input  1  reset: asynchronous assert, active-low.
- SCK  input  1  SPI clock from master; idle low.
- CSbar  input  1  chip select from master; active-low.
- MOSI  input  1  serial data from master.
- MISO  output  1  serial data to master.
- MISO_OE  output  1  MISO output-enable for the pad tristate.
- DATA_TX  input  WIDTH  reply word; sampled at frame start.
- DATA_RX  output  WIDTH  last complete received word; held between frames.
- RX_VALID  output  1  one-SYS_CLK pulse when DATA_RX updates.
- FRAME_ERR  output  1  one-SYS_CLK pulse when CSbar deasserts mid-frame.
- BUSY  output  1  high while a frame is in progress (state != IDLE).

Behaviour:
- Reset (RSTbar low, asynchronous):
  - All outputs are 0: MISO=0, MISO_OE=0, DATA_RX=0, RX_VALID=0, FRAME_ERR=0, BUSY=0.
  - State goes to IDLE; synchroniser and edge-history registers load idle values (SCK=0, CSbar=1).
  - Release is synchronous to SYS_CLK.
  - Reset mid-frame abandons the frame; no RX_VALID or FRAME_ERR is generated.
- Synchronisation and edge detection:
  - SCK, CSbar and MOSI each pass through SYNC_STAGES flops.
  - Edge detects compare the last synchroniser stage against a one-cycle history register: sck_rise, sck_fall, cs_fall, cs_rise.
  - MOSI is sampled from its synchronised copy in the same cycle as sck_rise.
- State machine: IDLE, SHIFT, DONE.
  - IDLE:
    - SCK edges are ignored.
    - On cs_fall: tx_shift <= DATA_TX, bit counter <= 0, go to SHIFT.
  - SHIFT:
    - On sck_rise: rx_shift <= {rx_shift[WIDTH-2:0], MOSI_sync}; counter +1.
    - On sck_fall: tx_shift <= {tx_shift[WIDTH-2:0], 0}. The shift happens only when counter is between 1 and WIDTH-1, so the first bit stays stable until the first rising edge.
    - When the counter reaches WIDTH on an sck_rise: the next cycle sets DATA_RX to the complete word and pulses RX_VALID, then go to DONE. Latency is 1 SYS_CLK after the detected 16th rising edge.
    - On cs_rise with counter < WIDTH: FRAME_ERR pulses for 1 cycle, DATA_RX is unchanged, go to IDLE.
  - DONE:
    - Further SCK edges are ignored and MISO drives 0.
    - On cs_rise: go to IDLE (no error).
- MISO and enables:
  - MISO = tx_shift[WIDTH-1] in SHIFT; 0 otherwise.
  - MISO_OE = 1 in SHIFT and DONE.
  - BUSY = MISO_OE.
- Simultaneous events:
  - cs_fall together with sck_rise in the same cycle: cs_fall wins and the SCK edge is dropped (this is a master setup violation).
  - cs_rise together with the final sck_rise: the bit is captured, RX_VALID fires, and FRAME_ERR stays low.
- DATA_TX is sampled only at cs_fall. Changes during a frame do not affect MISO.
- The bit counter is $clog2(WIDTH)+1 bits wide and never wraps within a frame.

Test Plan:
- Nominal frame: master sends 16'hA5C3 with DATA_TX=16'h3C5A and SCK = SYS_CLK/8 → DATA_RX=16'hA5C3 with a single RX_VALID pulse 1 cycle after the 16th synchronised SCK rise; master captures 16'h3C5A from MISO.
- Short frame: CSbar deasserts after 9 bits of 16'hFFFF, with prior DATA_RX=16'h1234 → FRAME_ERR pulses once, RX_VALID stays 0, DATA_RX stays 16'h1234, BUSY returns to 0.
- Over-clocked frame: 20 SCK pulses within one CSbar window → only the first 16 bits are captured; MISO=0 for pulses 17-20; RX_VALID pulses exactly once.
- Idle noise: SCK toggles 32 times with CSbar high → no state change; RX_VALID=0, FRAME_ERR=0, MISO_OE=0.
- Reset mid-frame: RSTbar pulled low after 8 bits → all outputs 0 immediately; the next full frame with 16'h0001 yields DATA_RX=16'h0001.
- Back-to-back frames: 16'h8001 then 16'h7FFE with CSbar high for 2 SCK periods between them, and DATA_TX changed during frame 1 → two RX_VALID pulses with the correct words; frame-1 MISO reflects DATA_TX as sampled at its cs_fall.
